serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor that reuses a single full-adder cell over WIDTH clock cycles. It processes one bit per cycle, LSB first. Operands are captured on a start strobe, and the result is presented with carry/borrow-out, signed overflow and a one-cycle done pulse. It serves as the area-cheap arithmetic unit for control paths where latency is not critical, replacing wide ripple chains of cascaded full adders.

---
 rtl/serial_adder.sv | 149 ++++++++++++++
 tb/tb_serial_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor. A single full-adder cell is reused over WIDTH
// clock cycles, one bit per cycle, LSB first. Operands are captured on a start
// strobe. The result, carry/borrow-out and signed overflow are loaded into
// output registers on the completing edge, and a one-cycle done pulse follows.
//
// Subtraction is performed as A + ~B + ~cin, so the internal carry chain is
// identical for both modes. Only the operand-B inversion, the initial carry
// and the sense of the final carry differ.
//
// Parameters:
//   WIDTH     operand/result width in bits (2..32)
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   sys_rst_n in   asynchronous active-low reset
//   start     in   request, sampled only when not busy (IDLE or DONE)
//   sub       in   0 = add, 1 = subtract (sampled with start)
//   in_1      in   operand A (sampled with start)
//   in_2      in   operand B (sampled with start)
//   cin       in   carry-in (add) / borrow-in (subtract), sampled with start
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse; result outputs valid from this cycle on
//   sum       out  result register
//   count     out  carry-out (add) / borrow-out (subtract)
//   overflow  out  two's-complement signed overflow of the result
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             count,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;      // operand A, shifted right each bit
    logic [WIDTH-1:0] b_r;      // operand B (pre-inverted when subtracting)
    logic [WIDTH-1:0] res_r;    // result bits enter at the MSB
    logic             c_r;      // running internal carry
    logic             sub_r;    // captured mode, needed to invert the final carry
    logic [CNT_W-1:0] cnt_r;    // index of the bit processed on the next edge

    logic             bit_s;    // result bit of the current position
    logic             carry_s;  // carry out of the current position
    logic             last_s;   // current position is the MSB

    // Full-adder carry: majority of the three inputs.
    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        fa_carry = (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder sum: parity of the three inputs.
    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        fa_sum = x ^ y ^ z;
    endfunction

    assign bit_s   = fa_sum(a_r[0], b_r[0], c_r);
    assign carry_s = fa_carry(a_r[0], b_r[0], c_r);
    assign last_s  = (cnt_r == CNT_W'(WIDTH - 1));

    // Control FSM and datapath: capture, bit-serial processing, result load.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
            c_r      <= 1'b0;
            sub_r    <= 1'b0;
            cnt_r    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            count    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_r)
                // DONE accepts a new request exactly like IDLE, which is what
                // allows back-to-back operations with start held high.
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= in_1;
                        b_r     <= sub ? ~in_2 : in_2;
                        c_r     <= cin ^ sub;   // ~cin when subtracting
                        sub_r   <= sub;
                        cnt_r   <= '0;
                        res_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end

                // start is deliberately ignored here.
                ST_RUN: begin
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    c_r   <= carry_s;
                    res_r <= {bit_s, res_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        // On the MSB, c_r is the carry into the MSB and
                        // carry_s the carry out of it.
                        sum      <= {bit_s, res_r[WIDTH-1:1]};
                        count    <= carry_s ^ sub_r;
                        overflow <= c_r ^ carry_s;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state_r  <= ST_RUN;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Scoreboard bench for serial_adder. Two instances (WIDTH=8 and WIDTH=16).
// Drivers push the hand-computed expected result, together with the cycle
// in which done must appear, into a queue per instance. A monitor per
// instance pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // Free-running edge counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance
    logic       st8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       busy8, done8, cnt8, ov8;
    logic [7:0] sum8;

    // WIDTH=16 instance
    logic        st16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic        busy16, done16, cnt16, ov16;
    logic [15:0] sum16;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(st8), .sub(sub8),
        .in_1(a8), .in_2(b8), .cin(cin8), .busy(busy8), .done(done8),
        .sum(sum8), .count(cnt8), .overflow(ov8)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(st16), .sub(sub16),
        .in_1(a16), .in_2(b16), .cin(cin16), .busy(busy16), .done(done16),
        .sum(sum16), .count(cnt16), .overflow(ov16)
    );

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        int          dcyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_run8 = 0;
    int   busy_run16 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ov, input int d);
        exp_t e;
        e.sum  = s;
        e.co   = co;
        e.ov   = ov;
        e.dcyc = d;
        return e;
    endfunction

    // Monitor for the WIDTH=8 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done8 actual=done required=no_done at cycle %0d", cyc);
                end else begin
                    e = q8.pop_front();
                    chk("sum8", {24'h0, sum8}, {16'h0, e.sum});
                    chk("count8", {31'h0, cnt8}, {31'h0, e.co});
                    chk("overflow8", {31'h0, ov8}, {31'h0, e.ov});
                    chk("done_cycle8", cyc, e.dcyc);
                    chk("busy_len8", busy_run8, 8);
                    chk("busy_in_done8", {31'h0, busy8}, 32'h0);
                end
                busy_run8 = 0;
            end else if (busy8) begin
                busy_run8++;
            end else begin
                busy_run8 = 0;
            end
        end
    end

    // Monitor for the WIDTH=16 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done16) begin
                if (q16.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done16 actual=done required=no_done at cycle %0d", cyc);
                end else begin
                    e = q16.pop_front();
                    chk("sum16", {16'h0, sum16}, {16'h0, e.sum});
                    chk("count16", {31'h0, cnt16}, {31'h0, e.co});
                    chk("overflow16", {31'h0, ov16}, {31'h0, e.ov});
                    chk("done_cycle16", cyc, e.dcyc);
                    chk("busy_len16", busy_run16, 16);
                    chk("busy_in_done16", {31'h0, busy16}, 32'h0);
                end
                busy_run16 = 0;
            end else if (busy16) begin
                busy_run16++;
            end else begin
                busy_run16 = 0;
            end
        end
    end

    // Issue one 8-bit request; returns at the falling edge after the start edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                          input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; sub8 = s; st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        q8.push_back(mk({8'h00, es}, ec, eo, cyc + 8));
        a8 = ~a; b8 = ~b; cin8 = ~c; sub8 = ~s;   // operands may change freely now
    endtask

    task automatic drain8();
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        checks++;
        if (q8.size() != 0) begin
            errors++;
            $display("FAIL timeout8 actual=%0d_pending required=0_pending", q8.size());
            q8.delete();
        end
        @(negedge clk);
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                           input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; sub16 = s; st16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st16 = 1'b0;
        q16.push_back(mk(es, ec, eo, cyc + 16));
        a16 = ~a; b16 = ~b;
    endtask

    task automatic drain16();
        for (int i = 0; i < 60 && q16.size() != 0; i++) @(negedge clk);
        checks++;
        if (q16.size() != 0) begin
            errors++;
            $display("FAIL timeout16 actual=%0d_pending required=0_pending", q16.size());
            q16.delete();
        end
        @(negedge clk);
    endtask

    // Directed stimulus.
    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset8", {20'h0, busy8, done8, cnt8, ov8, sum8}, 32'h0);
        chk("reset16", {12'h0, busy16, done16, cnt16, ov16, sum16}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic add / subtract / carry-in wrap
        start8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1); drain8();
        start8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0); drain8();
        start8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1); drain8();
        start8(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0); drain8();

        // start pulsed mid-RUN must be ignored
        start8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b1; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        drain8();
        repeat (12) @(negedge clk);

        // Back-to-back: start held high through DONE
        @(negedge clk);
        a8 = 8'h70; b8 = 8'h10; cin8 = 1'b0; sub8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        q8.push_back(mk(16'h0080, 1'b0, 1'b1, cyc + 8));
        a8 = 8'h01; b8 = 8'h01;
        repeat (9) @(negedge clk);   // now just after the edge that sampled start in DONE
        q8.push_back(mk(16'h0002, 1'b0, 1'b0, cyc + 8));
        st8 = 1'b0;
        drain8();

        // Reset during the 4th RUN cycle aborts the operation
        start8(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("busy_before_abort", {31'h0, busy8}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_reset8", {20'h0, busy8, done8, cnt8, ov8, sum8}, 32'h0);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        start8(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0); drain8();

        // WIDTH=16 instance
        start16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); drain16();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
